mem_io_responder: RTL

- Target-side counterpart of the CPU's byte-wide memory bus (address, data-out, write-enable, data-in, io_buffer_full).
- Provides 128 KB RAM with one-cycle registered read latency.
- Memory-maps the I/O window at mem_a[17:16]==2'b11: UART byte in/out, cycle counter, program-stop.
- Buffers outbound UART bytes in a TX FIFO and drives io_buffer_full back to the CPU.

---
 rtl/mem_io_responder_pkg.sv | 30 +++
 rtl/mem_io_responder_tx_fifo.sv | 80 ++++++++
 rtl/mem_io_responder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_io_responder_pkg.sv
// mem_io_responder_pkg
//   Shared definitions for the memory/I-O responder that sits on the CPU's
//   byte-wide memory bus: I/O window decode constants, byte/word types,
//   default RAM geometry and the cycle-counter byte selector.
package mem_io_responder_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  // I/O window select on mem_a[17:16]; 2'b10 still aliases into RAM.
  localparam logic [1:0]  IO_SEL       = 2'b11;
  localparam logic [17:0] IO_UART_ADDR = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;

  localparam int RAM_ADDR_W_DEF = 17;
  localparam int RAM_BYTES_DEF  = 1 << RAM_ADDR_W_DEF;

  // Byte 0 comes from the live counter; bytes 1..3 come from the snapshot
  // taken when byte 0 was read, so a 4-byte little-endian read is coherent.
  function automatic byte_t clk_byte(input word_t live, input word_t snap,
                                     input logic [1:0] sel);
    case (sel)
      2'd0:    return live[7:0];
      2'd1:    return snap[15:8];
      2'd2:    return snap[23:16];
      default: return snap[31:24];
    endcase
  endfunction

endpackage

// File: rtl/mem_io_responder_tx_fifo.sv
// mem_io_responder_tx_fifo
//   First-word-fall-through FIFO buffering outbound UART bytes.
//   A push into a full FIFO is dropped unless a pop happens in the same
//   cycle, in which case both take effect and the count is unchanged.
//   almost_full_o is registered and reflects the post-edge occupancy.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   push_i, din_i        write strobe and data
//   pop_i                consume head entry (ignored while empty)
//   dout_o               head entry, valid while !empty_o
//   empty_o              no entries held
//   almost_full_o        free slots <= MARGIN
//   count_o              number of entries held (0..DEPTH)
module mem_io_responder_tx_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int MARGIN = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       empty_o,
  output logic                       almost_full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MARGIN_C = CNT_W'(MARGIN);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             afull_q, afull_d;
  logic             full, do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign do_pop  = pop_i && (count_q != '0);
  // A simultaneous pop frees the slot this push needs.
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
    if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    afull_d  = (DEPTH_C - count_d) <= MARGIN_C;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      afull_q  <= afull_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o        = mem_q[rd_ptr_q];
  assign empty_o       = (count_q == '0);
  assign almost_full_o = afull_q;
  assign count_o       = count_q;

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder
//   Target side of the CPU byte-wide memory bus. Every cycle is a transaction.
//   mem_a[17:16]==2'b11 selects the I/O window, anything else addresses RAM
//   at mem_a[RAM_ADDR_W-1:0] with one-cycle registered read latency.
//   I/O map:
//     0x30000 read : RX byte (0 when none), pulses rx_pop when a byte is taken
//     0x30000 write: push non-zero byte to TX FIFO
//     0x30004..7 rd: cycle counter bytes, little-endian, coherent via snapshot
//     0x30004 write: push 8'h00 and set program_done
// Ports:
//   clk_in, rst_in        clock, asynchronous active-low reset
//   mem_a, mem_dout,      CPU address, write data, write enable
//   mem_wr
//   mem_din               read data, valid the cycle after the request
//   io_buffer_full        TX FIFO nearly full (registered)
//   tx_data, tx_valid,    UART TX stream (first-word-fall-through)
//   tx_ready
//   rx_data, rx_valid,    UART RX byte and its consume pulse
//   rx_pop
//   program_done          sticky stop flag
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int    RAM_ADDR_W  = RAM_ADDR_W_DEF,
  parameter int    TX_DEPTH    = 16,
  parameter int    FULL_MARGIN = 2,
  parameter string INIT_FILE   = "test.data"
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_done
);

  logic [17:0]           a18;
  logic                  io_sel, io_uart, io_clk;
  logic [RAM_ADDR_W-1:0] ram_addr;
  byte_t                 ram_q [2**RAM_ADDR_W];

  byte_t mem_din_q, mem_din_d;
  word_t cnt_q, snap_q, snap_d;
  logic  done_q, done_d;
  logic  push;
  byte_t push_data;
  logic  fifo_empty;
  logic [$clog2(TX_DEPTH):0] fifo_count;

  localparam bit unused_init_file = (INIT_FILE != "");

  assign a18      = mem_a[17:0];
  assign io_sel   = (a18[17:16] == IO_SEL);
  assign io_uart  = (a18 == IO_UART_ADDR);
  assign io_clk   = (a18[17:2] == IO_CLK_ADDR[17:2]);
  assign ram_addr = mem_a[RAM_ADDR_W-1:0];

  always_comb begin
    mem_din_d = mem_din_q;
    snap_d    = snap_q;
    done_d    = done_q;
    push      = 1'b0;
    push_data = mem_dout;
    if (mem_wr) begin
      if (io_uart) begin
        push = (mem_dout != 8'h00);
      end else if (a18 == IO_CLK_ADDR) begin
        push      = 1'b1;
        push_data = 8'h00;
        done_d    = 1'b1;
      end
    end else if (!io_sel) begin
      mem_din_d = ram_q[ram_addr];
    end else if (io_uart) begin
      mem_din_d = rx_valid ? rx_data : 8'h00;
    end else if (io_clk) begin
      mem_din_d = clk_byte(cnt_q, snap_q, a18[1:0]);
      if (a18[1:0] == 2'd0) snap_d = cnt_q;
    end else begin
      mem_din_d = 8'h00;
    end
  end

  // Held low during reset so a stale request cannot consume an RX byte.
  assign rx_pop = rst_in && !mem_wr && io_uart && rx_valid;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mem_din_q <= '0;
      cnt_q     <= '0;
      snap_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      mem_din_q <= mem_din_d;
      cnt_q     <= cnt_q + 32'd1;
      snap_q    <= snap_d;
      done_q    <= done_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk_in) begin
    if (mem_wr && !io_sel) ram_q[ram_addr] <= mem_dout;
  end

  mem_io_responder_tx_fifo #(
    .WIDTH  (8),
    .DEPTH  (TX_DEPTH),
    .MARGIN (FULL_MARGIN)
  ) u_tx_fifo (
    .clk_i         (clk_in),
    .rst_ni        (rst_in),
    .push_i        (push),
    .din_i         (push_data),
    .pop_i         (tx_valid && tx_ready),
    .dout_o        (tx_data),
    .empty_o       (fifo_empty),
    .almost_full_o (io_buffer_full),
    .count_o       (fifo_count)
  );

  assign tx_valid     = !fifo_empty;
  assign mem_din      = mem_din_q;
  assign program_done = done_q;

  logic unused_sink;
  assign unused_sink = ^{mem_a[31:18], fifo_count};

endmodule
